out_event_logger: RTL and testbench
===================================

OUT_EVENT_LOGGER -- requirements
Module: out_event_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning event FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter TS_W, default 11, meaning timestamp counter width.
REQ-003 SHALL have parameter CNT_W, default 3, meaning width of the occupancy output (log2(DEPTH)+1).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port obs_in  input  5  observed outputs of the upstream top (out1..out5 on bits 0..4), synchronous to clk.
REQ-007 SHALL have port clr_ovf  input  1  one-cycle pulse that clears the overflow flag.
REQ-008 SHALL have port evt_valid  output  1  FIFO head holds an event.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts the head event.
REQ-010 SHALL have port evt_data  output  5+TS_W  head event: vector on bits [TS_W+4:TS_W], timestamp on bits [TS_W-1:0].
REQ-011 SHALL have port evt_count  output  CNT_W  current FIFO occupancy, 0..DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky flag; an event was dropped.

Function
REQ-013 SHALL hold register prev (5 bits), loaded with obs_in on every rising edge.
REQ-014 SHALL detect a change event at an edge when obs_in != prev.
REQ-015 SHALL run a free-running TS_W-bit counter ts, +1 per cycle, wrapping from all-ones to 0.
REQ-016 SHALL push {obs_in, ts} on a change event, where ts is the counter value before that edge's increment.
REQ-017 SHALL implement the FIFO as show-ahead: evt_valid = (count != 0), and evt_data presents the oldest entry combinationally from storage.
REQ-018 SHALL pop on an edge with evt_valid && evt_ready; evt_ready while empty has no effect.
REQ-019 SHALL accept a push when count < DEPTH, or when count == DEPTH and a pop occurs on the same edge.
REQ-020 SHALL leave count unchanged on a simultaneous push and pop, and SHALL keep entry order.
REQ-021 SHALL, on a change event it cannot accept, drop the event, leave FIFO contents unchanged, and set overflow.
REQ-022 SHALL clear overflow on an edge with clr_ovf=1 unless a drop occurs on that same edge (set wins).
REQ-023 SHALL have a latency of 1: a change sampled at edge N into an empty FIFO gives evt_valid=1 after edge N.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH with no bubble.

Reset
REQ-025 SHALL, on rst_n low, immediately force prev=0, ts=0, pointers=0, count=0, overflow=0.
REQ-026 SHALL hold evt_valid=0 and evt_count=0 while in reset; evt_data is don't-care while evt_valid=0.
REQ-027 SHALL discard all queued events on reset mid-operation; the first edge after release compares obs_in against prev=0.

Configuration
REQ-028 SHALL use macro OUT_EVENT_LOGGER_TS_EN to control the timestamp feature.
REQ-029 SHALL, with OUT_EVENT_LOGGER_TS_EN defined, build the ts counter and store timestamps as specified above.
REQ-030 SHALL, without OUT_EVENT_LOGGER_TS_EN, omit the counter and storage, drive the evt_data timestamp field to 0, and keep port widths unchanged.

Verification
REQ-031 SHALL cover: reset release with obs_in=5'b00000 for 10 cycles -> evt_valid stays 0, evt_count=0.
REQ-032 SHALL cover: obs_in 0->5'b10101 sampled at the edge where ts=7, evt_ready=0 -> next cycle evt_valid=1, evt_data={5'b10101, 11'd7}, evt_count=1.
REQ-033 SHALL cover: 5 changes on consecutive cycles with evt_ready=0, DEPTH=4 -> evt_count=4, overflow=1, and the 4 oldest events are drained in order.
REQ-034 SHALL cover: FIFO full with evt_ready=1 while a new change arrives -> pop and push on the same edge, evt_count stays 4, overflow stays 0.
REQ-035 SHALL cover: ts run to 2047 then 0 with a change at each of those cycles -> stored timestamps are 2047 then 0.
REQ-036 SHALL cover: clr_ovf=1 on the same edge as a drop -> overflow remains 1; clr_ovf=1 on the next cycle -> overflow=0.

Source files
------------

// File: rtl/out_event_logger.sv
// -----------------------------------------------------------------------------
// out_event_logger
//
// Watches a 5-bit vector of upstream outputs. Whenever the vector changes, the
// logger queues an event {new vector, timestamp} in a small show-ahead FIFO
// for a downstream consumer. If the FIFO cannot take an event, the event is
// dropped and a sticky overflow flag is raised.
//
// Configuration macro: OUT_EVENT_LOGGER_TS_EN
//   defined   - a free-running TS_W-bit counter is built, and each event
//               stores the counter value seen at its capture edge.
//   undefined - no counter and no timestamp storage are built; the timestamp
//               field of evt_data reads as zero. Port widths do not change.
//
// Ports
//   clk        in   1        sole clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   obs_in     in   5        observed upstream outputs (out1..out5 on bits 0..4)
//   clr_ovf    in   1        pulse that clears overflow (a drop on the same edge wins)
//   evt_valid  out  1        FIFO head holds an event
//   evt_ready  in   1        consumer accepts the head event
//   evt_data   out  5+TS_W   head event: vector [TS_W+4:TS_W], timestamp [TS_W-1:0]
//   evt_count  out  CNT_W    FIFO occupancy, 0..DEPTH
//   overflow   out  1        sticky: at least one event was dropped
// -----------------------------------------------------------------------------
module out_event_logger #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 11,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        obs_in,
    input  logic              clr_ovf,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [TS_W+4:0]   evt_data,
    output logic [CNT_W-1:0]  evt_count,
    output logic              overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef OUT_EVENT_LOGGER_TS_EN
    localparam int ENTRY_W = 5 + TS_W;
`else
    localparam int ENTRY_W = 5;
`endif

    logic [4:0]         prev_r;
    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               overflow_r;

    logic               change_s;
    logic               pop_s;
    logic               full_s;
    logic               push_s;
    logic               drop_s;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               overflow_nxt_s;
    logic [ENTRY_W-1:0] wr_entry_s;

`ifdef OUT_EVENT_LOGGER_TS_EN
    logic [TS_W-1:0]    ts_r;

    // Free-running timestamp; wraps naturally from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r <= {TS_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end

    // ts_r is sampled before its increment, so the event carries the value
    // that was current at its capture edge.
    assign wr_entry_s = {obs_in, ts_r};
    assign evt_data   = mem_r[rd_ptr_r];
`else
    assign wr_entry_s = obs_in;
    assign evt_data   = {mem_r[rd_ptr_r], {TS_W{1'b0}}};
`endif

    // Handshake, change detection and acceptance decisions.
    always_comb begin
        change_s = 1'b0;
        pop_s    = 1'b0;
        full_s   = 1'b0;
        push_s   = 1'b0;
        drop_s   = 1'b0;
        change_s = (obs_in != prev_r);
        pop_s    = (count_r != {CNT_W{1'b0}}) && evt_ready;
        full_s   = (count_r == CNT_W'(DEPTH));
        // A full FIFO still accepts when the head leaves on the same edge.
        if (change_s && (!full_s || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (change_s && full_s && !pop_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // Next occupancy and next overflow flag.
    always_comb begin
        count_nxt_s    = count_r;
        overflow_nxt_s = overflow_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        // A drop on the same edge as a clear keeps the flag set.
        if (drop_s) begin
            overflow_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
    end

    // Previous-vector register, pointers, occupancy and overflow state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r     <= 5'b00000;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            prev_r     <= obs_in;
            count_r    <= count_nxt_s;
            overflow_r <= overflow_nxt_s;
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Event storage; contents are meaningless outside the occupied window.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    assign evt_valid = (count_r != {CNT_W{1'b0}});
    assign evt_count = count_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_out_event_logger.sv
module tb_out_event_logger;

    logic        clk;
    logic        rst_n;
    logic [4:0]  obs_in;
    logic        clr_ovf;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_data;
    logic [2:0]  evt_count;
    logic        overflow;

    int n_cmp;
    int n_err;

    out_event_logger #(.DEPTH(4), .TS_W(11), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .obs_in    (obs_in),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_count (evt_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected timestamp field: the stored value when timestamps are built, zero otherwise.
    function automatic logic [10:0] ts_exp(input logic [10:0] v);
`ifdef OUT_EVENT_LOGGER_TS_EN
        return v;
`else
        return 11'd0;
`endif
    endfunction

    // Advance one rising edge and settle just after it.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges; release just after an edge so the next edge is ts=0.
    task automatic do_reset;
        rst_n = 1'b0; obs_in = 5'd0; evt_ready = 1'b0; clr_ovf = 1'b0;
        step; step;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0 || overflow !== 1'b0) begin
            $display("FAIL reset_state: valid=%b count=%0d ovf=%b, want 0/0/0", evt_valid, evt_count, overflow);
            n_err++;
        end
        for (int i = 0; i < 10; i++) begin
            step;
            n_cmp++;
            if (evt_valid !== 1'b0 || evt_count !== 3'd0) begin
                $display("FAIL idle_after_reset cyc %0d: valid=%b count=%0d, want 0/0", i, evt_valid, evt_count);
                n_err++;
            end
        end
    endtask

    task automatic test_single;
        logic [15:0] exp;
        do_reset;
        repeat (7) step;             // edges with ts 0..6
        obs_in = 5'b10101;           // captured at the ts=7 edge
        step;
        exp = {5'b10101, ts_exp(11'd7)};
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_count !== 3'd1 || evt_data !== exp) begin
            $display("FAIL single_event: valid=%b count=%0d data=%h, want 1/1/%h", evt_valid, evt_count, evt_data, exp);
            n_err++;
        end
        evt_ready = 1'b1;
        step;
        evt_ready = 1'b0;
        n_cmp++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0) begin
            $display("FAIL single_pop: valid=%b count=%0d, want 0/0", evt_valid, evt_count);
            n_err++;
        end
        // Ready on an empty FIFO must do nothing.
        evt_ready = 1'b1;
        step;
        evt_ready = 1'b0;
        n_cmp++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0) begin
            $display("FAIL ready_when_empty: valid=%b count=%0d, want 0/0", evt_valid, evt_count);
            n_err++;
        end
    endtask

    task automatic test_overflow;
        logic [15:0] exp;
        do_reset;
        for (int i = 1; i <= 5; i++) begin
            obs_in = 5'(i);          // changes at edges ts=0..4; the fifth is dropped
            step;
        end
        n_cmp++;
        if (evt_count !== 3'd4 || overflow !== 1'b1) begin
            $display("FAIL overflow_set: count=%0d ovf=%b, want 4/1", evt_count, overflow);
            n_err++;
        end
        obs_in = 5'd6; clr_ovf = 1'b1;   // drop and clear on the same edge
        step;
        n_cmp++;
        if (evt_count !== 3'd4 || overflow !== 1'b1) begin
            $display("FAIL clear_vs_drop: count=%0d ovf=%b, want 4/1", evt_count, overflow);
            n_err++;
        end
        step;                            // clear with no change
        clr_ovf = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            $display("FAIL clear_ovf: ovf=%b, want 0", overflow);
            n_err++;
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = {5'(i + 1), ts_exp(11'(i))};
            n_cmp++;
            if (evt_valid !== 1'b1 || evt_data !== exp) begin
                $display("FAIL drain_order %0d: valid=%b data=%h, want 1/%h", i, evt_valid, evt_data, exp);
                n_err++;
            end
            step;
        end
        evt_ready = 1'b0;
        n_cmp++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0) begin
            $display("FAIL drained_empty: valid=%b count=%0d, want 0/0", evt_valid, evt_count);
            n_err++;
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp;
        do_reset;
        for (int i = 1; i <= 4; i++) begin
            obs_in = 5'(i);          // ts 0..3
            step;
        end
        obs_in = 5'd5; evt_ready = 1'b1; // push at ts=4 with simultaneous pop
        step;
        evt_ready = 1'b0;
        exp = {5'd2, ts_exp(11'd1)};
        n_cmp++;
        if (evt_count !== 3'd4 || overflow !== 1'b0 || evt_data !== exp) begin
            $display("FAIL full_push_pop: count=%0d ovf=%b data=%h, want 4/0/%h", evt_count, overflow, evt_data, exp);
            n_err++;
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = {5'(i + 2), ts_exp(11'(i + 1))};
            n_cmp++;
            if (evt_valid !== 1'b1 || evt_data !== exp) begin
                $display("FAIL b2b_order %0d: valid=%b data=%h, want 1/%h", i, evt_valid, evt_data, exp);
                n_err++;
            end
            step;
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_ts_wrap;
        logic [15:0] exp;
        do_reset;
        repeat (2047) step;          // edges ts 0..2046
        obs_in = 5'd1;               // ts=2047
        step;
        obs_in = 5'd2;               // ts=0 after wrap
        step;
        exp = {5'd1, ts_exp(11'd2047)};
        n_cmp++;
        if (evt_count !== 3'd2 || evt_data !== exp) begin
            $display("FAIL ts_2047: count=%0d data=%h, want 2/%h", evt_count, evt_data, exp);
            n_err++;
        end
        evt_ready = 1'b1;
        step;
        evt_ready = 1'b0;
        exp = {5'd2, ts_exp(11'd0)};
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_data !== exp) begin
            $display("FAIL ts_wrap0: valid=%b data=%h, want 1/%h", evt_valid, evt_data, exp);
            n_err++;
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] exp;
        do_reset;
        obs_in = 5'd1; step;
        obs_in = 5'd3; step;
        rst_n = 1'b0;                // asynchronous, mid-cycle
        #1;
        n_cmp++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0 || overflow !== 1'b0) begin
            $display("FAIL reset_mid: valid=%b count=%0d ovf=%b, want 0/0/0", evt_valid, evt_count, overflow);
            n_err++;
        end
        step;
        rst_n = 1'b1;                // obs_in stays 3, prev is 0 -> event at ts=0
        step;
        exp = {5'd3, ts_exp(11'd0)};
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_count !== 3'd1 || evt_data !== exp) begin
            $display("FAIL after_reset_event: valid=%b count=%0d data=%h, want 1/1/%h", evt_valid, evt_count, evt_data, exp);
            n_err++;
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; obs_in = 5'd0; clr_ovf = 1'b0; evt_ready = 1'b0;
        test_reset;
        test_single;
        test_overflow;
        test_back_to_back;
        test_ts_wrap;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
